// File: rtl/mem_access_unit.sv
// Load/store initiator between the core MEM stage and a word-addressed data memory.
// Checks natural alignment, issues one memory transaction per request, formats load data.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 64,
    parameter int MEM_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_wen,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [2:0]                req_funct3,
    input  logic [63:0]               req_wdata,
    output logic                      resp_valid,
    output logic                      resp_error,
    output logic [63:0]               resp_rdata,
    input  logic                      mem_ready,
    output logic                      mem_valid,
    output logic                      mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]               mem_wdata,
    output logic [7:0]                mem_wmask,
    input  logic                      mem_rvalid,
    input  logic [63:0]               mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    localparam int AW = MEM_ADDR_WIDTH + 3;

    state_t        state_r;
    state_t        state_s;
    logic          wen_r;
    logic [AW-1:0] addr_r;
    logic [2:0]    funct3_r;
    logic [63:0]   wdata_r;
    logic [7:0]    wmask_r;
    logic          resp_valid_r;
    logic          resp_error_r;
    logic [63:0]   resp_rdata_r;
    logic          req_err_s;
    logic          unused_addr_s;

    function automatic logic access_error(input logic wen, input logic [2:0] f3, input logic [2:0] off);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            2'b10:   mis = (off[1:0] != 2'b00);
            2'b11:   mis = (off != 3'b000);
            default: mis = 1'b1;
        endcase
        return mis | (~wen & (f3 == 3'b111)) | (wen & f3[2]);
    endfunction

    function automatic logic [63:0] store_lanes(input logic [2:0] f3, input logic [63:0] d);
        logic [63:0] r;
        case (f3[1:0])
            2'b00:   r = {8{d[7:0]}};
            2'b01:   r = {4{d[15:0]}};
            2'b10:   r = {2{d[31:0]}};
            2'b11:   r = d;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] store_mask(input logic [2:0] f3, input logic [2:0] off);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01 << off;
            2'b01:   m = 8'h03 << off;
            2'b10:   m = 8'h0F << off;
            2'b11:   m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] load_format(input logic [2:0] f3, input logic [2:0] off,
                                                input logic [63:0] rdata);
        logic [63:0] s;
        logic [63:0] r;
        s = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{56{s[7]}}, s[7:0]};
            3'b001:  r = {{48{s[15]}}, s[15:0]};
            3'b010:  r = {{32{s[31]}}, s[31:0]};
            3'b011:  r = s;
            3'b100:  r = {56'd0, s[7:0]};
            3'b101:  r = {48'd0, s[15:0]};
            3'b110:  r = {32'd0, s[31:0]};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Next-state logic; rejected requests never leave IDLE.
    always_comb begin
        state_s   = state_r;
        req_err_s = access_error(req_wen, req_funct3, req_addr[2:0]);
        case (state_r)
            IDLE: begin
                if (req_valid && !req_err_s) state_s = ISSUE;
                else                         state_s = IDLE;
            end
            ISSUE: begin
                if (mem_ready) state_s = WAIT;
                else           state_s = ISSUE;
            end
            WAIT: begin
                if (mem_rvalid) state_s = IDLE;
                else            state_s = WAIT;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_s;
    end

    // Request capture (store lanes pre-formatted at accept) and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_r        <= 1'b0;
            addr_r       <= '0;
            funct3_r     <= 3'd0;
            wdata_r      <= 64'd0;
            wmask_r      <= 8'd0;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_rdata_r <= 64'd0;
        end else begin
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_rdata_r <= 64'd0;
            if (state_r == IDLE && req_valid) begin
                wen_r        <= req_wen;
                addr_r       <= req_addr[AW-1:0];
                funct3_r     <= req_funct3;
                wdata_r      <= req_wen ? store_lanes(req_funct3, req_wdata) : 64'd0;
                wmask_r      <= req_wen ? store_mask(req_funct3, req_addr[2:0]) : 8'd0;
                resp_valid_r <= req_err_s;
                resp_error_r <= req_err_s;
            end
            if (state_r == WAIT && mem_rvalid) begin
                resp_valid_r <= 1'b1;
                resp_rdata_r <= wen_r ? 64'd0 : load_format(funct3_r, addr_r[2:0], mem_rdata);
            end
        end
    end

    assign unused_addr_s = ^req_addr[ADDR_WIDTH-1:AW];

    assign req_ready  = (state_r == IDLE);
    assign mem_valid  = (state_r == ISSUE);
    assign mem_wen    = wen_r;
    assign mem_addr   = addr_r[AW-1:3];
    assign mem_wdata  = wdata_r;
    assign mem_wmask  = wmask_r;
    assign resp_valid = resp_valid_r;
    assign resp_error = resp_error_r;
    assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, scoreboard of responses,
// behavioural word memory, plus stall and mid-transaction reset sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_error;
    logic [63:0] resp_rdata;
    logic        mem_ready = 1'b1;
    logic        mem_valid;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    mem_access_unit #(.ADDR_WIDTH(64), .MEM_ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int txn_cnt = 0;
    int mv_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural memory: reads answer next cycle, writes two cycles after acceptance.
    logic [63:0] mem_m [0:255];
    logic        init_mem = 1'b1;
    logic        hold_resp = 1'b0;
    logic        inject_rvalid = 1'b0;
    logic        wr_pend = 1'b0;
    logic [15:0] cap_addr = 16'd0;
    logic [63:0] cap_wdata = 64'd0;
    logic [7:0]  cap_wmask = 8'd0;
    logic        cap_wen = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_valid) mv_cycles <= mv_cycles + 1;
        mem_rvalid <= inject_rvalid;
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_m[i] <= 64'd0;
            mem_m[2] <= 64'h8877665544332211;
        end
        if (wr_pend) begin
            mem_rvalid <= 1'b1;
            wr_pend    <= 1'b0;
        end
        if (mem_valid && mem_ready) begin
            txn_cnt   <= txn_cnt + 1;
            cap_addr  <= mem_addr;
            cap_wdata <= mem_wdata;
            cap_wmask <= mem_wmask;
            cap_wen   <= mem_wen;
            if (mem_wen) begin
                for (int b = 0; b < 8; b++)
                    if (mem_wmask[b]) mem_m[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                wr_pend <= 1'b1;
            end else if (!hold_resp) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem_m[mem_addr[7:0]];
            end
        end
    end

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          due;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    // Response monitor: every resp_valid must match the oldest expectation, on its cycle.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            resp_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_error", resp_error, mon_e.err);
                chk("resp_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic do_req(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [63:0] er, input logic ee,
                          input int lat, input logic push);
        @(negedge clk);
        chk("req_ready", req_ready, 64'd1);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        if (push) sb_q.push_back('{er, ee, cyc + lat});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 0;
        while (sb_q.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (sb_q.size() != 0) begin
            chk("resp_timeout", 64'd1, 64'd0);
            sb_q.delete();
        end
    endtask

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_maddr;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_mwdata;
        int          lat;
    } vec_t;
    vec_t vec[18];

    initial begin
        int t0;
        int m0;
        int r0;
        logic [15:0] a0;
        logic [63:0] w0;
        logic [7:0]  k0;

        vec[0]  = '{1'b0, 3'b000, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 16'd2, 8'h00, 64'h0, 3};
        vec[1]  = '{1'b0, 3'b101, 64'h12, 64'h0, 64'h0000000000004433, 1'b0, 16'd2, 8'h00, 64'h0, 3};
        vec[2]  = '{1'b0, 3'b010, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 1'b0, 16'd2, 8'h00, 64'h0, 3};
        vec[3]  = '{1'b0, 3'b011, 64'h10, 64'h0, 64'h8877665544332211, 1'b0, 16'd2, 8'h00, 64'h0, 3};
        vec[4]  = '{1'b1, 3'b001, 64'h14, 64'h1234, 64'h0, 1'b0, 16'd2, 8'h30, 64'h1234123412341234, 4};
        vec[5]  = '{1'b0, 3'b011, 64'h10, 64'h0, 64'h8877123444332211, 1'b0, 16'd2, 8'h00, 64'h0, 3};
        vec[6]  = '{1'b0, 3'b100, 64'h11, 64'h0, 64'h0000000000000022, 1'b0, 16'd2, 8'h00, 64'h0, 3};
        vec[7]  = '{1'b1, 3'b000, 64'h1B, 64'hFFFFFFFFFFFFFFAB, 64'h0, 1'b0, 16'd3, 8'h08, 64'hABABABABABABABAB, 4};
        vec[8]  = '{1'b0, 3'b110, 64'h18, 64'h0, 64'h00000000AB000000, 1'b0, 16'd3, 8'h00, 64'h0, 3};
        vec[9]  = '{1'b1, 3'b010, 64'h1C, 64'h11112222DEADBEEF, 64'h0, 1'b0, 16'd3, 8'hF0, 64'hDEADBEEFDEADBEEF, 4};
        vec[10] = '{1'b0, 3'b011, 64'h18, 64'h0, 64'hDEADBEEFAB000000, 1'b0, 16'd3, 8'h00, 64'h0, 3};
        vec[11] = '{1'b0, 3'b001, 64'h1E, 64'h0, 64'hFFFFFFFFFFFFDEAD, 1'b0, 16'd3, 8'h00, 64'h0, 3};
        vec[12] = '{1'b1, 3'b011, 64'h20, 64'h0123456789ABCDEF, 64'h0, 1'b0, 16'd4, 8'hFF, 64'h0123456789ABCDEF, 4};
        vec[13] = '{1'b0, 3'b011, 64'hFFFF000000000020, 64'h0, 64'h0123456789ABCDEF, 1'b0, 16'd4, 8'h00, 64'h0, 3};
        vec[14] = '{1'b0, 3'b010, 64'h0A, 64'h0, 64'h0, 1'b1, 16'd0, 8'h00, 64'h0, 1};
        vec[15] = '{1'b1, 3'b011, 64'h04, 64'h55, 64'h0, 1'b1, 16'd0, 8'h00, 64'h0, 1};
        vec[16] = '{1'b0, 3'b111, 64'h00, 64'h0, 64'h0, 1'b1, 16'd0, 8'h00, 64'h0, 1};
        vec[17] = '{1'b1, 3'b100, 64'h00, 64'h77, 64'h0, 1'b1, 16'd0, 8'h00, 64'h0, 1};

        repeat (3) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 64'd0);
        chk("rst_resp_error", resp_error, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_mem_valid", mem_valid, 64'd0);
        chk("rst_req_ready", req_ready, 64'd1);
        rst = 1'b1;
        init_mem = 1'b0;

        for (int i = 0; i < 18; i++) begin
            t0 = txn_cnt;
            m0 = mv_cycles;
            do_req(vec[i].wen, vec[i].f3, vec[i].addr, vec[i].wd,
                   vec[i].exp_rdata, vec[i].exp_err, vec[i].lat, 1'b1);
            wait_done();
            if (vec[i].exp_err) begin
                chk("err_no_mem_valid", mv_cycles - m0, 64'd0);
            end else begin
                chk("mem_txn_count", txn_cnt - t0, 64'd1);
                chk("mem_addr", cap_addr, vec[i].exp_maddr);
                chk("mem_wmask", cap_wmask, vec[i].exp_wmask);
                chk("mem_wdata", cap_wdata, vec[i].exp_mwdata);
                chk("mem_wen", cap_wen, vec[i].wen);
            end
        end

        // Stall in ISSUE for three cycles with a stray rvalid pulse.
        mem_ready = 1'b0;
        do_req(1'b0, 3'b011, 64'h10, 64'h0, 64'h8877123444332211, 1'b0, 6, 1'b1);
        chk("stall_mem_valid", mem_valid, 64'd1);
        a0 = mem_addr;
        w0 = mem_wdata;
        k0 = mem_wmask;
        inject_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            inject_rvalid = 1'b0;
            if (k == 2) mem_ready = 1'b1;
            chk("stall_mem_valid", mem_valid, 64'd1);
            chk("stall_mem_addr", mem_addr, a0);
            chk("stall_mem_wdata", mem_wdata, w0);
            chk("stall_mem_wmask", mem_wmask, k0);
        end
        chk("stall_addr_value", a0, 64'd2);
        wait_done();

        // Reset while waiting for the memory; the late completion must be dropped.
        hold_resp = 1'b1;
        r0 = resp_cnt;
        do_req(1'b0, 3'b011, 64'h10, 64'h0, 64'h0, 1'b0, 3, 1'b0);
        @(negedge clk);
        chk("wait_req_ready", req_ready, 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("arst_resp_valid", resp_valid, 64'd0);
        chk("arst_mem_valid", mem_valid, 64'd0);
        chk("arst_req_ready", req_ready, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        hold_resp = 1'b0;
        inject_rvalid = 1'b1;
        @(negedge clk);
        inject_rvalid = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_rvalid_no_resp", resp_cnt - r0, 64'd0);
        chk("post_rst_req_ready", req_ready, 64'd1);

        do_req(1'b0, 3'b011, 64'h20, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3, 1'b1);
        wait_done();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
